spi_cfg_master: RTL and testbench



---
 rtl/spi_cfg_pkg.sv | 28 ++
 rtl/rr_arb2.sv | 33 +++
 rtl/spi_cfg_master.sv | 166 ++++++++++++++++
 tb/tb_spi_cfg_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared constants, state encoding and frame packing for the SPI config master.
// Frame layout: {write flag, 7-bit register address, 8-bit data}, MSB first.
package spi_cfg_pkg;

    localparam int         FRAME_BITS = 16;
    localparam logic       WR_FLAG    = 1'b1;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_LO,
        SHIFT_HI,
        TRAIL,
        GAP
    } state_e;

    function automatic logic [FRAME_BITS-1:0] wr_frame(input logic [6:0] addr,
                                                       input logic [7:0] data);
        return {WR_FLAG, addr, data};
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational from requests and pointer.
// Pointer moves to the other requester on each accept strobe; no backpressure of its own.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic [1:0] gnt_o
);

    // Requester favoured when both request; 0 after reset.
    logic prio_q, prio_d;

    always_comb begin
        gnt_o  = req_i;
        prio_d = prio_q;
        if (req_i[0] && req_i[1]) begin
            gnt_o = prio_q ? 2'b10 : 2'b01;
        end
        if (accept_i && (|gnt_o)) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/spi_cfg_master.sv
// Arbitrates two register-write requesters and emits one 16-bit SPI mode-0 write frame per grant.
// Frame spans 33*CLK_DIV cycles of ncs low plus a CLK_DIV gap; requesters stall (ready low) outside IDLE.
module spi_cfg_master
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [6:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [6:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       sclk,
    output logic       copi,
    output logic       ncs,
    output logic       busy,
    output logic       done,
    output logic       done_id
);

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("spi_cfg_master: CLK_DIV must lie in 2..255");
    end

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    state_e                 state_q, state_d;
    logic [DIV_W-1:0]       div_q, div_d;
    logic [4:0]             bit_q, bit_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic                   id_q, id_d;
    logic                   sclk_q, sclk_d;
    logic                   copi_q, copi_d;
    logic                   ncs_q, ncs_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   done_id_q, done_id_d;

    logic [1:0] gnt;
    logic       accept;
    logic       phase_end;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (accept),
        .gnt_o    (gnt)
    );

    assign req0_ready = (state_q == IDLE) && gnt[0];
    assign req1_ready = (state_q == IDLE) && gnt[1];
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign phase_end  = (div_q == '0);

    always_comb begin
        state_d   = state_q;
        div_d     = phase_end ? DIV_LOAD : div_q - 1'b1;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        id_d      = id_q;
        sclk_d    = sclk_q;
        copi_d    = copi_q;
        ncs_d     = ncs_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;

        unique case (state_q)
            IDLE: begin
                div_d = DIV_LOAD;
                if (accept) begin
                    shreg_d = gnt[1] ? wr_frame(req1_addr, req1_data)
                                     : wr_frame(req0_addr, req0_data);
                    id_d    = gnt[1];
                    bit_d   = 5'd0;
                    copi_d  = WR_FLAG;
                    sclk_d  = 1'b0;
                    ncs_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = LEAD;
                end
            end
            LEAD, SHIFT_LO: begin
                if (phase_end) begin
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    sclk_d = 1'b0;
                    bit_d  = bit_q + 5'd1;
                    if (bit_q == 5'(FRAME_BITS - 1)) begin
                        copi_d  = 1'b0;
                        state_d = TRAIL;
                    end else begin
                        // Rotate so the next bit sits below the MSB; copi changes on the falling edge.
                        copi_d  = shreg_q[FRAME_BITS-2];
                        shreg_d = {shreg_q[FRAME_BITS-2:0], shreg_q[FRAME_BITS-1]};
                        state_d = SHIFT_LO;
                    end
                end
            end
            TRAIL: begin
                if (phase_end) begin
                    ncs_d     = 1'b1;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (phase_end) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= DIV_LOAD;
            bit_q     <= 5'd0;
            shreg_q   <= '0;
            id_q      <= 1'b0;
            sclk_q    <= 1'b0;
            copi_q    <= 1'b0;
            ncs_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            id_q      <= id_d;
            sclk_q    <= sclk_d;
            copi_q    <= copi_d;
            ncs_q     <= ncs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    assign sclk    = sclk_q;
    assign copi    = copi_q;
    assign ncs     = ncs_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
// Directed bench: two masters (CLK_DIV=4 and CLK_DIV=2) each drive a behavioural peripheral
// that decodes frames, measures ncs/sclk phase lengths and holds the five config registers.
module tb_spi_cfg_master;
    import spi_cfg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req1_valid, b_valid, b1_valid;
    logic [6:0] req0_addr, req1_addr, b_addr, b1_addr;
    logic [7:0] req0_data, req1_data, b_data, b1_data;
    logic       req0_ready, req1_ready, b_ready, b1_ready;
    logic [1:0] sclk_w, copi_w, ncs_w, busy_w, done_w, done_id_w;

    int checks = 0;
    int errors = 0;

    spi_cfg_master #(.CLK_DIV(4)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .sclk(sclk_w[0]), .copi(copi_w[0]), .ncs(ncs_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .done_id(done_id_w[0])
    );

    spi_cfg_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(b_valid), .req0_addr(b_addr), .req0_data(b_data), .req0_ready(b_ready),
        .req1_valid(b1_valid), .req1_addr(b1_addr), .req1_data(b1_data), .req1_ready(b1_ready),
        .sclk(sclk_w[1]), .copi(copi_w[1]), .ncs(ncs_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .done_id(done_id_w[1])
    );

    // Peripheral model: samples the SPI pins on clk like the real 2-flop synchroniser.
    for (genvar g = 0; g < 2; g++) begin : g_per
        logic        sclk_p, ncs_p;
        logic [15:0] sh, last_frame;
        logic [7:0]  regs [5];
        int cnt, last_cnt, low_run, low_len, run, min_ph, max_ph;
        int done_cnt = 0;
        int last_done_id = 0;

        always @(posedge clk) begin
            if (done_w[g]) begin
                done_cnt     <= done_cnt + 1;
                last_done_id <= int'(done_id_w[g]);
            end
            if (!rst_n) begin
                sclk_p  <= 1'b0;
                ncs_p   <= 1'b1;
                cnt     <= 0;
                run     <= 0;
                low_run <= 0;
                for (int i = 0; i < 5; i++) regs[i] <= 8'h00;
            end else begin
                sclk_p <= sclk_w[g];
                ncs_p  <= ncs_w[g];
                if (ncs_p && !ncs_w[g]) begin
                    low_run <= 1;
                    run     <= 1;
                    cnt     <= 0;
                    min_ph  <= 9999;
                    max_ph  <= 0;
                end else if (!ncs_w[g]) begin
                    low_run <= low_run + 1;
                    if (sclk_w[g] == sclk_p) begin
                        run <= run + 1;
                    end else begin
                        run <= 1;
                        if (run < min_ph) min_ph <= run;
                        if (run > max_ph) max_ph <= run;
                    end
                    if (sclk_w[g] && !sclk_p) begin
                        sh  <= {sh[14:0], copi_w[g]};
                        cnt <= cnt + 1;
                    end
                end else if (!ncs_p) begin
                    if (run < min_ph) min_ph <= run;
                    if (run > max_ph) max_ph <= run;
                    last_frame <= sh;
                    last_cnt   <= cnt;
                    low_len    <= low_run;
                    if (cnt == 16 && sh[15] && sh[14:8] < 7'd5) regs[sh[10:8]] <= sh[7:0];
                end
            end
        end
    end

    int cyc = 0;
    int acc_id_q[$];
    int acc_cyc_q[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && req0_valid && req0_ready) begin
            acc_id_q.push_back(0);
            acc_cyc_q.push_back(cyc);
        end
        if (rst_n && req1_valid && req1_ready) begin
            acc_id_q.push_back(1);
            acc_cyc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int done_count(input int g);
        return (g == 0) ? g_per[0].done_cnt : g_per[1].done_cnt;
    endfunction

    function automatic logic [39:0] regs0_cat();
        return {g_per[0].regs[0], g_per[0].regs[1], g_per[0].regs[2],
                g_per[0].regs[3], g_per[0].regs[4]};
    endfunction

    task automatic send(input int id, input logic [6:0] a, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        if (id == 0) begin
            req0_valid = 1'b1; req0_addr = a; req0_data = d;
        end else begin
            req1_valid = 1'b1; req1_addr = a; req1_data = d;
        end
        #1;
        while (!((id == 0) ? req0_ready : req1_ready) && t < 5000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq($sformatf("accept_wait%0d", id), (t < 5000), 1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else         req1_valid = 1'b0;
    endtask

    task automatic wait_done(input int g, input int n);
        int t = 0;
        while (done_count(g) < n && t < 6000) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_wait", (t < 6000), 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t;
        int base;
        logic [39:0] snap;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
        b1_valid = 1'b0; b1_addr = '0; b1_data = '0;
        do_reset();

        // Reset state
        check_eq("rst_sclk", sclk_w[0], 0);
        check_eq("rst_copi", copi_w[0], 0);
        check_eq("rst_ncs", ncs_w[0], 1);
        check_eq("rst_busy", busy_w[0], 0);
        check_eq("rst_done", done_w[0], 0);
        check_eq("rst_done_id", done_id_w[0], 0);

        // Single write to PWM duty
        base = done_count(0);
        send(0, ADDR_PWM_DUTY, 8'h80);
        check_eq("busy_after_acc", busy_w[0], 1);
        check_eq("ready_low_busy", req0_ready, 0);
        wait_done(0, base + 1);
        check_eq("t1_frame", g_per[0].last_frame, 16'h8480);
        check_eq("t1_bits", g_per[0].last_cnt, 16);
        check_eq("t1_ncs_low", g_per[0].low_len, 132);
        check_eq("t1_min_phase", g_per[0].min_ph, 4);
        check_eq("t1_max_phase", g_per[0].max_ph, 4);
        check_eq("t1_done_id", g_per[0].last_done_id, 0);
        check_eq("t1_pwm_duty", g_per[0].regs[4], 8'h80);

        // Simultaneous requests right after reset
        do_reset();
        acc_id_q.delete(); acc_cyc_q.delete();
        base = done_count(0);
        fork
            send(0, ADDR_EN_OUT_LO, 8'hFF);
            send(1, ADDR_EN_PWM_LO, 8'h0F);
        join
        wait_done(0, base + 2);
        check_eq("t2_n_acc", acc_id_q.size(), 2);
        check_eq("t2_first", acc_id_q[0], 0);
        check_eq("t2_second", acc_id_q[1], 1);
        check_eq("t2_spacing", acc_cyc_q[1] - acc_cyc_q[0], 137);
        check_eq("t2_en_out_lo", g_per[0].regs[0], 8'hFF);
        check_eq("t2_en_pwm_lo", g_per[0].regs[2], 8'h0F);

        // Both requesters held valid for four frames
        acc_id_q.delete(); acc_cyc_q.delete();
        base = done_count(0);
        fork
            begin
                send(0, ADDR_EN_PWM_HI, 8'h11);
                send(0, ADDR_EN_PWM_HI, 8'h22);
            end
            begin
                send(1, ADDR_EN_OUT_HI, 8'h33);
                send(1, ADDR_EN_OUT_HI, 8'h44);
            end
        join
        wait_done(0, base + 4);
        check_eq("t3_n_acc", acc_id_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t3_grant%0d", i), acc_id_q[i], i % 2);
        end
        for (int i = 1; i < 4; i++) begin
            check_eq($sformatf("t3_gap%0d", i), acc_cyc_q[i] - acc_cyc_q[i-1], 137);
        end

        // Out-of-range address: frame goes out, registers untouched
        snap = regs0_cat();
        base = done_count(0);
        send(1, 7'd7, 8'h55);
        wait_done(0, base + 1);
        check_eq("t4_frame", g_per[0].last_frame, 16'h8755);
        check_eq("t4_done_id", g_per[0].last_done_id, 1);
        check_eq("t4_regs_same", regs0_cat(), snap);

        // Reset mid-frame after five sclk rises
        send(0, ADDR_EN_PWM_HI, 8'h3C);
        t = 0;
        while (g_per[0].cnt != 5 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check_eq("t5_five_rises", (t < 2000), 1);
        base = done_count(0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("t5_ncs", ncs_w[0], 1);
        check_eq("t5_sclk", sclk_w[0], 0);
        check_eq("t5_busy", busy_w[0], 0);
        check_eq("t5_done", done_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        check_eq("t5_no_done", done_count(0), base);
        check_eq("t5_idle_ncs", ncs_w[0], 1);
        send(0, ADDR_EN_OUT_HI, 8'hA5);
        wait_done(0, base + 1);
        check_eq("t5_frame", g_per[0].last_frame, 16'h81A5);
        check_eq("t5_en_out_hi", g_per[0].regs[1], 8'hA5);

        // CLK_DIV=2 instance
        @(negedge clk);
        b_valid = 1'b1; b_addr = ADDR_EN_OUT_HI; b_data = 8'h33;
        #1;
        t = 0;
        while (!b_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        check_eq("d2_accept_wait", (t < 1000), 1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        wait_done(1, 1);
        check_eq("d2_frame", g_per[1].last_frame, 16'h8133);
        check_eq("d2_bits", g_per[1].last_cnt, 16);
        check_eq("d2_ncs_low", g_per[1].low_len, 66);
        check_eq("d2_min_phase", g_per[1].min_ph, 2);
        check_eq("d2_max_phase", g_per[1].max_ph, 2);
        check_eq("d2_en_out_hi", g_per[1].regs[1], 8'h33);
        check_eq("d2_done_id", g_per[1].last_done_id, 0);
        check_eq("d2_r1_ready", b1_ready, 0);
        repeat (5) @(negedge clk);
        check_eq("d2_busy_idle", busy_w[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
